// File: rtl/br_update_ctrl.sv
// Branch resolution controller: mispredict flush/redirect plus a training FIFO.
// Optional stats counters are enabled with `define BR_STATS_EN.
module br_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_npc,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             stall_ex,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [15:0]      br_cnt,
  output logic [15:0]      mp_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [31:0]      tgt;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_redirect;

  logic w_accept;
  logic w_mp;
  logic w_pop;
  ent_t w_ent;
  ent_t w_head;

  // Only the index bits of the PC are trained.
  logic w_unused;
  assign w_unused = ^{ex_pc[31:IDX_W+2], ex_pc[1:0]};

  assign stall_ex = (r_cnt == CNT_FULL);
  assign upd_valid = (r_cnt != '0);
  assign w_pop = upd_valid && upd_ready;
  assign w_accept = ex_valid && !stall_ex && (r_state == RUN);

  assign w_mp = (ex_taken != ex_pred_taken) ||
                (ex_taken && ex_pred_taken &&
                 (ex_target != ex_pred_target));

  assign w_ent.idx = ex_pc[IDX_W+1:2];
  assign w_ent.taken = ex_taken;
  assign w_ent.tgt = ex_target;

  assign w_head = r_mem[r_rp];
  assign upd_index = w_head.idx;
  assign upd_taken = w_head.taken;
  assign upd_target = w_head.tgt;

  assign flush = (r_state == FLUSH);
  assign redirect_pc = r_redirect;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:   if (w_accept && w_mp) w_state_nxt = FLUSH;
      FLUSH: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_redirect <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_mp)
        r_redirect <= ex_taken ? ex_target : ex_npc;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wp] <= w_ent;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      unique case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef BR_STATS_EN
  logic [15:0] r_br_cnt;
  logic [15:0] r_mp_cnt;

  // Saturating so long runs never wrap back to small values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_accept && (r_br_cnt != 16'hFFFF))
        r_br_cnt <= r_br_cnt + 16'd1;
      if (w_accept && w_mp && (r_mp_cnt != 16'hFFFF))
        r_mp_cnt <= r_mp_cnt + 16'd1;
    end
  end

  assign br_cnt = r_br_cnt;
  assign mp_cnt = r_mp_cnt;
`else
  assign br_cnt = '0;
  assign mp_cnt = '0;
`endif

endmodule

// File: tb/tb_br_update_ctrl.sv
// Self-checking bench for br_update_ctrl; training entries go through a
// scoreboard queue checked whenever the predictor write handshake fires.
module tb_br_update_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] ex_npc = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [1:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        stall_ex;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt;
  logic [15:0] mp_cnt;

`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int passed = 0;
  int total = 0;
  logic [15:0] exp_br = '0;
  logic [15:0] exp_mp = '0;
  logic [34:0] sb[$];

  br_update_ctrl #(.DEPTH(4), .IDX_W(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_npc(ex_npc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_target(upd_target), .stall_ex(stall_ex), .flush(flush),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: compare every predictor write against the enqueue order.
  always @(negedge CLK) begin
    if (nRST && upd_valid && upd_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected got=%0h_%0h_%0h exp=none",
                 upd_index, upd_taken, upd_target);
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        if ({upd_index, upd_taken, upd_target} !== e)
          $display("FAIL sb_entry got=%0h exp=%0h",
                   {upd_index, upd_taken, upd_target}, e);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic drive_br(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] npc,
                          input logic ptk, input logic [31:0] ptgt,
                          input bit acc);
    logic mp;
    ex_valid = 1'b1;
    ex_pc = pc;
    ex_taken = tk;
    ex_target = tgt;
    ex_npc = npc;
    ex_pred_taken = ptk;
    ex_pred_target = ptgt;
    mp = (tk != ptk) || (tk && ptk && tgt != ptgt);
    if (acc) begin
      sb.push_back({pc[3:2], tk, tgt});
      exp_br = sat_inc(exp_br);
      if (mp) exp_mp = sat_inc(exp_mp);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #2;
    total++;
    if ({upd_valid, stall_ex, flush} !== 3'b000)
      $display("FAIL rst_ctl got=%b exp=000", {upd_valid, stall_ex, flush});
    else passed++;
    total++;
    if ({upd_index, upd_taken, upd_target} !== 35'd0)
      $display("FAIL rst_head got=%0h exp=0",
               {upd_index, upd_taken, upd_target});
    else passed++;
    total++;
    if ({redirect_pc, br_cnt, mp_cnt} !== 64'd0)
      $display("FAIL rst_regs got=%0h exp=0", {redirect_pc, br_cnt, mp_cnt});
    else passed++;
    step();
    step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_correct();
    upd_ready = 1'b1;
    drive_br(32'h8, 1'b1, 32'h40, 32'hC, 1'b1, 32'h40, 1'b1);
    total++;
    if (upd_valid !== 1'b0)
      $display("FAIL corr_lat got=%b exp=0", upd_valid);
    else passed++;
    step();
    ex_valid = 1'b0;
    total++;
    if (flush !== 1'b0) $display("FAIL corr_flush got=%b exp=0", flush);
    else passed++;
    total++;
    if ({upd_valid, upd_index, upd_taken, upd_target} !== {1'b1, 2'd2, 1'b1, 32'h40})
      $display("FAIL corr_head got=%b_%0d_%b_%0h exp=1_2_1_40",
               upd_valid, upd_index, upd_taken, upd_target);
    else passed++;
    total++;
    if (br_cnt !== (STATS ? 16'd1 : 16'd0) || mp_cnt !== 16'd0)
      $display("FAIL corr_cnt got=%0d/%0d exp=%0d/0", br_cnt, mp_cnt,
               STATS ? 1 : 0);
    else passed++;
    step();
    total++;
    if (upd_valid !== 1'b0) $display("FAIL corr_drain got=%b exp=0", upd_valid);
    else passed++;
  endtask

  task automatic test_dir_mp();
    drive_br(32'hC, 1'b0, 32'h100, 32'h10, 1'b1, 32'h44, 1'b1);
    step();
    drive_br(32'h20, 1'b1, 32'h60, 32'h24, 1'b1, 32'h60, 1'b0);
    total++;
    if ({flush, redirect_pc} !== {1'b1, 32'h10})
      $display("FAIL dir_flush got=%b_%0h exp=1_10", flush, redirect_pc);
    else passed++;
    total++;
    if (mp_cnt !== (STATS ? exp_mp : 16'd0))
      $display("FAIL dir_mpcnt got=%0d exp=%0d", mp_cnt,
               STATS ? exp_mp : 16'd0);
    else passed++;
    step();
    ex_valid = 1'b0;
    total++;
    if (flush !== 1'b0) $display("FAIL dir_oneshot got=%b exp=0", flush);
    else passed++;
    total++;
    if (upd_valid !== 1'b0)
      $display("FAIL dir_wrongpath got=%b exp=0", upd_valid);
    else passed++;
  endtask

  task automatic test_tgt_mp();
    drive_br(32'h14, 1'b1, 32'h80, 32'h18, 1'b1, 32'h44, 1'b1);
    step();
    ex_valid = 1'b0;
    total++;
    if ({flush, redirect_pc} !== {1'b1, 32'h80})
      $display("FAIL tgt_flush got=%b_%0h exp=1_80", flush, redirect_pc);
    else passed++;
    step();
    total++;
    if (flush !== 1'b0) $display("FAIL tgt_oneshot got=%b exp=0", flush);
    else passed++;
  endtask

  task automatic test_backpressure();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_br(32'h100 + 32'(4 * i), 1'(i), 32'h200 + 32'(16 * i),
               32'h104 + 32'(4 * i), 1'(i), 32'h200 + 32'(16 * i), 1'b1);
      step();
    end
    total++;
    if (stall_ex !== 1'b1) $display("FAIL bp_full got=%b exp=1", stall_ex);
    else passed++;
    drive_br(32'h300, 1'b1, 32'h400, 32'h304, 1'b0, 32'h0, 1'b0);
    step();
    ex_valid = 1'b0;
    total++;
    if (stall_ex !== 1'b1) $display("FAIL bp_hold got=%b exp=1", stall_ex);
    else passed++;
    upd_ready = 1'b1;
    #1;
    total++;
    if (stall_ex !== 1'b1) $display("FAIL bp_popstall got=%b exp=1", stall_ex);
    else passed++;
    step();
    upd_ready = 1'b0;
    total++;
    if (stall_ex !== 1'b0) $display("FAIL bp_release got=%b exp=0", stall_ex);
    else passed++;
    total++;
    if (flush !== 1'b0) $display("FAIL bp_noflush got=%b exp=0", flush);
    else passed++;
    upd_ready = 1'b1;
    for (int i = 0; i < 10 && upd_valid; i++) step();
    total++;
    if (upd_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL bp_drain got=%b/%0d exp=0/0", upd_valid, sb.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    upd_ready = 1'b0;
    drive_br(32'h500, 1'b1, 32'h600, 32'h504, 1'b1, 32'h600, 1'b1);
    step();
    drive_br(32'h504, 1'b0, 32'h700, 32'h508, 1'b0, 32'h0, 1'b1);
    step();
    drive_br(32'h508, 1'b1, 32'h800, 32'h50C, 1'b0, 32'h0, 1'b1);
    step();
    ex_valid = 1'b0;
    total++;
    if ({flush, upd_valid} !== 2'b11)
      $display("FAIL mid_pre got=%b exp=11", {flush, upd_valid});
    else passed++;
    #2;
    nRST = 1'b0;
    #1;
    sb.delete();
    exp_br = '0;
    exp_mp = '0;
    total++;
    if ({upd_valid, flush, stall_ex} !== 3'b000)
      $display("FAIL mid_async got=%b exp=000", {upd_valid, flush, stall_ex});
    else passed++;
    total++;
    if ({br_cnt, mp_cnt, redirect_pc} !== 64'd0)
      $display("FAIL mid_regs got=%0h exp=0", {br_cnt, mp_cnt, redirect_pc});
    else passed++;
    step();
    nRST = 1'b1;
    upd_ready = 1'b1;
    step();
    total++;
    if ({upd_valid, flush} !== 2'b00)
      $display("FAIL mid_after got=%b exp=00", {upd_valid, flush});
    else passed++;
  endtask

  task automatic test_stats();
`ifdef BR_STATS_EN
    upd_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive_br(32'h40, 1'b1, 32'h90, 32'h44, 1'b1, 32'h90, 1'b1);
      step();
    end
    ex_valid = 1'b0;
    total++;
    if (br_cnt !== 16'hFFFF) $display("FAIL sat_br got=%0h exp=ffff", br_cnt);
    else passed++;
    step();
`else
    drive_br(32'h44, 1'b0, 32'h90, 32'h48, 1'b1, 32'h90, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    total++;
    if ({br_cnt, mp_cnt} !== 32'd0)
      $display("FAIL nostats got=%0h/%0h exp=0/0", br_cnt, mp_cnt);
    else passed++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mp();
    test_tgt_mp();
    test_backpressure();
    test_reset_mid();
    test_stats();
    total++;
    if (sb.size() != 0) $display("FAIL sb_left got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
